// File: rtl/axi2apb_mux_wdt_if.sv
// axi2apb_mux_wdt_if: bridge-side and slave-side APB bundle for the mux.
// Modport slave is the mux view; modport master is the environment view.
interface axi2apb_mux_wdt_if #(
  parameter int NUM_SLAVES = 8,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
);
  logic [SEL_WIDTH-1:0]             ctrl_addr_mux;
  logic                             ctrl_psel;
  logic                             ctrl_penable;
  logic [DATA_WIDTH-1:0]            ctrl_prdata;
  logic                             ctrl_pready;
  logic                             ctrl_pslverr;
  logic                             ctrl_timeout;
  logic [NUM_SLAVES-1:0]            slv_psel;
  logic [NUM_SLAVES-1:0]            slv_penable;
  logic [NUM_SLAVES-1:0]            slv_pready;
  logic [NUM_SLAVES-1:0]            slv_pslverr;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] slv_prdata;

  modport slave (
    input  ctrl_addr_mux, ctrl_psel, ctrl_penable,
    input  slv_pready, slv_pslverr, slv_prdata,
    output ctrl_prdata, ctrl_pready, ctrl_pslverr, ctrl_timeout,
    output slv_psel, slv_penable
  );

  modport master (
    output ctrl_addr_mux, ctrl_psel, ctrl_penable,
    output slv_pready, slv_pslverr, slv_prdata,
    input  ctrl_prdata, ctrl_pready, ctrl_pslverr, ctrl_timeout,
    input  slv_psel, slv_penable
  );
endinterface

// File: rtl/axi2apb_mux_wdt.sv
// axi2apb_mux_wdt: APB slave-select mux with phase tracker and watchdog.
// Define AXI2APB_MUX_WDT_ERRCNT_EN for saturating error/timeout counters.
module axi2apb_mux_wdt #(
  parameter int NUM_SLAVES     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_CNT_WIDTH   = 8
) (
  input  logic ACLK,
  input  logic ARESET,
`ifdef AXI2APB_MUX_WDT_ERRCNT_EN
  output logic [15:0] dec_err_cnt,
  output logic [15:0] timeout_cnt,
`endif
  axi2apb_mux_wdt_if.slave bus
);

  localparam bit CAN_DEC_ERR = (NUM_SLAVES < (1 << SEL_WIDTH));
  localparam logic [SEL_WIDTH:0] NS_LIM = (SEL_WIDTH+1)'(NUM_SLAVES);
  localparam logic [TO_CNT_WIDTH-1:0] TO_LIM = TO_CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam bit WDT_ON = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, ACCESS, ABORTED} state_t;

  state_t                  state, state_n;
  logic [SEL_WIDTH-1:0]    sel_q;
  logic                    dec_err_q;
  logic [TO_CNT_WIDTH-1:0] to_cnt, to_cnt_n;
  logic                    capture;
  logic                    dec_err_in;
  logic                    setup, enable;
  logic [NUM_SLAVES-1:0]   hot_in, hot_q;
  logic                    s_ready, s_err;
  logic [DATA_WIDTH-1:0]   s_data;

  assign setup  = bus.ctrl_psel & ~bus.ctrl_penable;
  assign enable = bus.ctrl_psel & bus.ctrl_penable;
  assign dec_err_in = CAN_DEC_ERR &&
                      ({1'b0, bus.ctrl_addr_mux} >= NS_LIM);

  // Decode incoming and latched slave index; mux latched slave's response.
  always_comb begin
    hot_in  = '0;
    hot_q   = '0;
    s_ready = 1'b0;
    s_err   = 1'b0;
    s_data  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hot_in[i] = (bus.ctrl_addr_mux == SEL_WIDTH'(i));
      hot_q[i]  = (sel_q == SEL_WIDTH'(i));
      if (hot_q[i]) begin
        s_ready = bus.slv_pready[i];
        s_err   = bus.slv_pslverr[i];
        s_data  = bus.slv_prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Phase tracker next-state, watchdog and all bus outputs.
  always_comb begin
    state_n          = state;
    to_cnt_n         = to_cnt;
    capture          = 1'b0;
    bus.slv_psel     = '0;
    bus.slv_penable  = '0;
    bus.ctrl_pready  = 1'b0;
    bus.ctrl_pslverr = 1'b0;
    bus.ctrl_prdata  = '0;
    bus.ctrl_timeout = 1'b0;
    if (!ARESET) begin
      unique case (state)
        IDLE: begin
          if (setup) begin
            capture      = 1'b1;
            bus.slv_psel = hot_in;
            state_n      = ACCESS;
          end else if (enable) begin
            bus.ctrl_pready  = 1'b1;
            bus.ctrl_pslverr = 1'b1;
          end
        end
        ACCESS: begin
          if (!bus.ctrl_psel) begin
            state_n  = IDLE;
            to_cnt_n = '0;
          end else if (dec_err_q) begin
            if (bus.ctrl_penable) begin
              bus.ctrl_pready  = 1'b1;
              bus.ctrl_pslverr = 1'b1;
              state_n          = IDLE;
              to_cnt_n         = '0;
            end
          end else begin
            bus.slv_psel    = hot_q;
            bus.slv_penable = hot_q & {NUM_SLAVES{bus.ctrl_penable}};
            if (bus.ctrl_penable) begin
              if (s_ready) begin
                bus.ctrl_pready  = 1'b1;
                bus.ctrl_pslverr = s_err;
                bus.ctrl_prdata  = s_data;
                state_n          = IDLE;
                to_cnt_n         = '0;
              end else if (WDT_ON && to_cnt == TO_LIM) begin
                bus.ctrl_pready  = 1'b1;
                bus.ctrl_pslverr = 1'b1;
                bus.ctrl_timeout = 1'b1;
                state_n          = ABORTED;
                to_cnt_n         = '0;
              end else begin
                to_cnt_n = to_cnt + TO_CNT_WIDTH'(1);
              end
            end
          end
        end
        ABORTED: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // State, watchdog counter and setup-cycle capture of the slave index.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= IDLE;
      to_cnt    <= '0;
      sel_q     <= '0;
      dec_err_q <= 1'b0;
    end else begin
      state  <= state_n;
      to_cnt <= to_cnt_n;
      if (capture) begin
        sel_q     <= bus.ctrl_addr_mux;
        dec_err_q <= dec_err_in;
      end
    end
  end

`ifdef AXI2APB_MUX_WDT_ERRCNT_EN
  logic dec_evt;
  assign dec_evt = bus.ctrl_pready & bus.ctrl_pslverr & ~bus.ctrl_timeout &
                   ((state == IDLE) | dec_err_q);

  // Saturating counts of decode/protocol errors and watchdog aborts.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      dec_err_cnt <= '0;
      timeout_cnt <= '0;
    end else begin
      if (dec_evt && dec_err_cnt != 16'hFFFF)
        dec_err_cnt <= dec_err_cnt + 16'd1;
      if (bus.ctrl_timeout && timeout_cnt != 16'hFFFF)
        timeout_cnt <= timeout_cnt + 16'd1;
    end
  end
`endif

endmodule
